// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for the multicycle RV32I core, driving datapath enables and mux selects
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Op,
    input  logic       MemReady,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       Illegal,
    output logic [3:0] State
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic [3:0] r_state;
    logic [3:0] w_next;

    always_ff @(posedge clk) begin
        r_state <= reset ? RESET_STATE : w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE:   w_next = (Op == OP_LW || Op == OP_SW) ? S_MEMADR :
                                 (Op == OP_R)   ? S_EXECUTER :
                                 (Op == OP_I)   ? S_EXECUTEI :
                                 (Op == OP_BEQ) ? S_BEQ :
                                 (Op == OP_JAL) ? S_JAL : S_TRAP;
            S_MEMADR:   w_next = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    // FETCH gates IR/PC loads on the handshake so a stalled fetch never advances the PC
    always_comb begin
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        Illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCUpdate  = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            S_TRAP: Illegal = 1'b1;
            default: ;
        endcase
    end

    // TRAP is absorbing, so deriving Illegal from the state keeps it sticky until reset
    assign ImmSrc = (Op == OP_SW)  ? 2'b01 :
                    (Op == OP_BEQ) ? 2'b10 :
                    (Op == OP_JAL) ? 2'b11 : 2'b00;
    assign State = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed instruction sequences checked every cycle against a per-state control table model
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       MemReady = 1'b1;
    logic [6:0] Op = 7'd0;
    logic       PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] State;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
        .PCUpdate(PCUpdate), .Branch(Branch), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    typedef struct packed {
        logic pc, br, ir, rw, mw, adr;
        logic [1:0] rs, sa, sb, ao;
        logic ill;
    } ctrl_t;

    typedef struct {
        logic [3:0] s;
        logic       mr;
        logic [6:0] op;
    } ent_t;

    ctrl_t tab [12];
    ent_t  q[$];
    int checks = 0, errors = 0;
    int cyc_n = 0, mw_n = 0, rw_n = 0, br_n = 0, pc_n = 0, ill_n = 0;
    int s_cyc, s_mw, s_rw, s_br, s_pc, s_ill;

    initial begin
        //               pc    br    ir    rw    mw    adr   rs     sa     sb     ao     ill
        tab[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
        tab[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
        tab[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
        tab[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        tab[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        tab[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        tab[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
        tab[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
        tab[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        tab[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
        tab[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
        tab[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
    end

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        return op == SW ? 2'd1 : op == BQ ? 2'd2 : op == JL ? 2'd3 : 2'd0;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            automatic ent_t  e = q.pop_front();
            automatic ctrl_t x = tab[e.s];
            automatic ctrl_t g = {PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc,
                                  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal};
            if (e.s == 4'd0) begin
                x.ir = e.mr;
                x.pc = e.mr;
            end
            chk("State", 32'(State), 32'(e.s));
            chk($sformatf("ctrl in state %0d", e.s), 32'(g), 32'(x));
            chk("ImmSrc", 32'(ImmSrc), 32'(imm_of(e.op)));
            cyc_n++;
            mw_n  += int'(MemWrite);
            rw_n  += int'(RegWrite);
            br_n  += int'(Branch);
            pc_n  += int'(PCUpdate);
            ill_n += int'(Illegal);
        end
    end

    task automatic cyc(input logic [3:0] s, input logic mr, input logic rs);
        MemReady = mr;
        reset    = rs;
        q.push_back('{s, mr, Op});
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_cyc = cyc_n; s_mw = mw_n; s_rw = rw_n; s_br = br_n; s_pc = pc_n; s_ill = ill_n;
    endtask

    task automatic run(input logic [6:0] op, input int fs, input int ms);
        Op = op;
        repeat (fs) cyc(4'd0, 1'b0, 1'b0);
        cyc(4'd0, 1'b1, 1'b0);
        cyc(4'd1, rb(), 1'b0);
        case (op)
            LW: begin
                cyc(4'd2, rb(), 1'b0);
                repeat (ms) cyc(4'd3, 1'b0, 1'b0);
                cyc(4'd3, 1'b1, 1'b0);
                cyc(4'd4, rb(), 1'b0);
            end
            SW: begin
                cyc(4'd2, rb(), 1'b0);
                repeat (ms) cyc(4'd5, 1'b0, 1'b0);
                cyc(4'd5, 1'b1, 1'b0);
            end
            RT: begin cyc(4'd6, rb(), 1'b0); cyc(4'd8, rb(), 1'b0); end
            IT: begin cyc(4'd7, rb(), 1'b0); cyc(4'd8, rb(), 1'b0); end
            BQ: cyc(4'd9, rb(), 1'b0);
            JL: begin cyc(4'd10, rb(), 1'b0); cyc(4'd8, rb(), 1'b0); end
            default: repeat (19) cyc(4'd11, rb(), 1'b0);
        endcase
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset State", 32'(State), 32'd0);
        chk("reset IRWrite", 32'(IRWrite), 32'd1);
        chk("reset PCUpdate", 32'(PCUpdate), 32'd1);
        chk("reset ALUSrcB", 32'(ALUSrcB), 32'd2);
        chk("reset ResultSrc", 32'(ResultSrc), 32'd2);
        chk("reset Illegal", 32'(Illegal), 32'd0);
        snap(); run(LW, 0, 0);
        chk("lw cycles", 32'(cyc_n - s_cyc), 32'd5);
        chk("lw regwrite", 32'(rw_n - s_rw), 32'd1);
        snap(); run(SW, 0, 3);
        chk("sw cycles", 32'(cyc_n - s_cyc), 32'd7);
        chk("sw memwrite", 32'(mw_n - s_mw), 32'd4);
        snap(); run(BQ, 0, 0);
        chk("beq cycles", 32'(cyc_n - s_cyc), 32'd3);
        chk("beq branch", 32'(br_n - s_br), 32'd1);
        chk("beq no writes", 32'(rw_n - s_rw + mw_n - s_mw), 32'd0);
        snap(); run(JL, 0, 0);
        chk("jal cycles", 32'(cyc_n - s_cyc), 32'd4);
        chk("jal pcupdate", 32'(pc_n - s_pc), 32'd2);
        chk("jal regwrite", 32'(rw_n - s_rw), 32'd1);
        snap(); run(RT, 2, 0);
        chk("rtype cycles", 32'(cyc_n - s_cyc), 32'd6);
        snap(); run(IT, 0, 0);
        chk("itype cycles", 32'(cyc_n - s_cyc), 32'd4);
        snap(); run(LW, 1, 2);
        chk("lw stall cycles", 32'(cyc_n - s_cyc), 32'd8);
        snap();
        Op = SW;
        cyc(4'd0, 1'b1, 1'b0);
        cyc(4'd1, rb(), 1'b0);
        cyc(4'd2, rb(), 1'b0);
        cyc(4'd5, 1'b0, 1'b0);
        cyc(4'd5, 1'b0, 1'b1);
        cyc(4'd0, 1'b0, 1'b0);
        chk("sw reset memwrite", 32'(mw_n - s_mw), 32'd2);
        snap(); run(7'b1111111, 0, 0);
        cyc(4'd11, 1'b1, 1'b1);
        chk("trap illegal cycles", 32'(ill_n - s_ill), 32'd20);
        snap(); run(RT, 0, 0);
        chk("post-trap illegal", 32'(ill_n - s_ill), 32'd0);
        #10;
        chk("queue drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle RV32I core: one shared memory port, one ALU and non-architectural latches (IR, OldPC, A, WriteData, ALUOut, Data).
- Drives per-state datapath enables and mux selects.
- Decodes Op to select the instruction path and the immediate format.
- Stalls on a memory-ready handshake; traps on unsupported opcodes.

Parameters:
- RESET_STATE, 4'd0: state entered on reset (FETCH); must be a valid state encoding.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Op  input  7  opcode field from the IR
- MemReady  input  1  memory handshake; current access completes in this cycle
- PCUpdate  output  1  PC register write enable
- Branch  output  1  datapath ANDs with Zero to load the PC
- IRWrite  output  1  IR and OldPC load enable
- RegWrite  output  1  register file write enable
- MemWrite  output  1  memory write strobe
- AdrSrc  output  1  address mux: 0 = PC, 1 = Result
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A
- ALUSrcB  output  2  00 = WriteData, 01 = ImmExt, 10 = constant 4
- ALUOp  output  2  00 = add, 01 = subtract/compare, 10 = funct-decoded
- ImmSrc  output  2  00 = I, 01 = S, 10 = B, 11 = J
- Illegal  output  1  sticky unsupported-opcode flag
- State  output  4  current state, for debug

Behaviour:
- Moore FSM with a registered state. All outputs are combinational from State. ImmSrc alone is combinational from Op.
- Exceptions to pure Moore: IRWrite and PCUpdate in FETCH, and MemWrite in MEMWRITE, are additionally gated or held per the handshake rules below.
- Reset: State = FETCH, Illegal = 0. Every enable is driven 0 except the FETCH outputs, which follow State.
- Default for every output in every state: 0 / 2'b00. Only the deviations are listed below.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11.
- FETCH: ALUSrcB = 10, ResultSrc = 10; IRWrite = PCUpdate = MemReady. MemReady = 0 -> hold FETCH; MemReady = 1 -> DECODE.
- DECODE: ALUSrcA = 01, ALUSrcB = 01 (branch target into ALUOut). Next state by Op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - otherwise -> TRAP
- MEMADR: ALUSrcA = 10, ALUSrcB = 01. Next: Op 0000011 -> MEMREAD, else MEMWRITE.
- MEMREAD: AdrSrc = 1. Hold until MemReady = 1, then MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1 -> FETCH.
- MEMWRITE: AdrSrc = 1, MemWrite = 1, held every cycle until MemReady = 1; then -> FETCH.
- EXECUTER: ALUSrcA = 10, ALUOp = 10 -> ALUWB.
- EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10 -> ALUWB.
- ALUWB: RegWrite = 1 -> FETCH.
- BEQ: ALUSrcA = 10, ALUOp = 01, Branch = 1 -> FETCH.
- JAL: ALUSrcA = 01, ALUSrcB = 10, PCUpdate = 1 (PC <- ALUOut target) -> ALUWB (rd <- OldPC + 4).
- TRAP: Illegal = 1. All enables 0. TRAP is absorbing; only reset leaves it.
- ImmSrc by Op: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.
- Unmapped State encodings (12–15): next state = FETCH, outputs = defaults.
- Reset asserted mid-instruction, including during a stalled access: FETCH on the next edge; in-flight MemWrite drops with that edge.
- Cycle counts with MemReady tied high:
  - lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4.
  - Each cycle of MemReady = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle.

Test Plan:
- Reset with MemReady = 1, then release -> State = 0, IRWrite = 1, PCUpdate = 1, ALUSrcB = 10, ResultSrc = 10, Illegal = 0.
- Op = 0000011, MemReady = 1 -> states 0, 1, 2, 3, 4, 0. RegWrite = 1 only in state 4, with ResultSrc = 01; ImmSrc = 00.
- Op = 0100011, MemReady low for 3 cycles in MEMWRITE -> MemWrite = 1 and AdrSrc = 1 for 4 consecutive cycles; ImmSrc = 01; return to FETCH after MemReady.
- Op = 1100011 -> states 0, 1, 9, 0. Branch = 1 and ALUOp = 01 only in state 9; ImmSrc = 10; no RegWrite or MemWrite pulses.
- Op = 1101111 -> states 0, 1, 10, 8, 0. PCUpdate = 1 in state 10; RegWrite = 1 in state 8; ImmSrc = 11.
- Op = 1111111 -> TRAP (11), Illegal = 1 held for 20 cycles. Assert reset -> State = 0, Illegal = 0 on the next edge.
